// File: rtl/simple_cpu_pkg.sv
// ---------------------------------------------------------------------------
// simple_cpu_pkg
// Shared definitions for the 8-bit accumulator CPU sequencer:
//   - opcode byte values (OP_NOP .. OP_HLT)
//   - ALU operation encodings driven on alu_op
//   - sequencer state enum
//   - instruction decode helpers
// ---------------------------------------------------------------------------
package simple_cpu_pkg;

   localparam logic [7:0] OP_NOP  = 8'h00;
   localparam logic [7:0] OP_LDI  = 8'h01;
   localparam logic [7:0] OP_ADDI = 8'h02;
   localparam logic [7:0] OP_SUBI = 8'h03;
   localparam logic [7:0] OP_ANDI = 8'h04;
   localparam logic [7:0] OP_LDA  = 8'h05;
   localparam logic [7:0] OP_STA  = 8'h06;
   localparam logic [7:0] OP_JMP  = 8'h07;
   localparam logic [7:0] OP_JZ   = 8'h08;
   localparam logic [7:0] OP_HLT  = 8'hFF;

   localparam logic [1:0] ALU_PASS = 2'b00;
   localparam logic [1:0] ALU_ADD  = 2'b01;
   localparam logic [1:0] ALU_SUB  = 2'b10;
   localparam logic [1:0] ALU_AND  = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH_OP,
      ST_FETCH_ARG,
      ST_MEM_ACC,
      ST_EXECUTE,
      ST_HALTED
   } state_e;

   // Execute-time view of an opcode held in IR.
   typedef struct packed {
      logic       mem_acc;   // LDA/STA: needs a data-memory access
      logic       acc_wr;    // writes the accumulator in EXECUTE
      logic [1:0] alu_op;
      logic       is_jmp;
      logic       is_jz;
      logic       is_hlt;
      logic       illegal;   // undefined opcode, runs as NOP
   } dec_t;

   // Opcodes 0x01..0x08 carry a one-byte argument after the opcode.
   function automatic logic op_has_arg(input logic [7:0] op);
      return (op >= OP_LDI) && (op <= OP_JZ);
   endfunction

   function automatic dec_t decode(input logic [7:0] op);
      dec_t d;
      d        = '0;
      d.alu_op = ALU_PASS;
      case (op)
         OP_NOP:  d.illegal = 1'b0;
         OP_LDI:  d.acc_wr  = 1'b1;
         OP_ADDI: begin d.acc_wr = 1'b1; d.alu_op = ALU_ADD; end
         OP_SUBI: begin d.acc_wr = 1'b1; d.alu_op = ALU_SUB; end
         OP_ANDI: begin d.acc_wr = 1'b1; d.alu_op = ALU_AND; end
         OP_LDA:  begin d.acc_wr = 1'b1; d.mem_acc = 1'b1; end
         OP_STA:  d.mem_acc = 1'b1;
         OP_JMP:  d.is_jmp  = 1'b1;
         OP_JZ:   d.is_jz   = 1'b1;
         OP_HLT:  d.is_hlt  = 1'b1;
         default: d.illegal = 1'b1;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/simple_cpu_seq_if.sv
// ---------------------------------------------------------------------------
// simple_cpu_seq_if
// Request/acknowledge memory port between the sequencer (master) and the
// instruction/data memory (slave).
//   req   : request, held until ack
//   we    : 1 = write, 0 = read
//   addr  : request address
//   wdata : write data
//   rdata : read data, valid in the ack cycle
//   ack   : completes the current request
// ---------------------------------------------------------------------------
interface simple_cpu_seq_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 8
);
   logic              req;
   logic              we;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic [DATA_W-1:0] rdata;
   logic              ack;

   modport master (output req, we, addr, wdata, input rdata, ack);
   modport slave  (input req, we, addr, wdata, output rdata, ack);
endinterface

// File: rtl/simple_cpu_seq.sv
// ---------------------------------------------------------------------------
// simple_cpu_seq
// Fetch/decode/execute sequencer for the 8-bit accumulator CPU. Owns PC and
// IR, fetches over a req/ack memory port and drives the accumulator datapath.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   start             : pulse, starts execution from IDLE or HALTED
//   mem               : memory port (master side)
//   acc_q, acc_zero   : accumulator value and zero flag from the datapath
//   alu_op, operand   : ALU control and B operand
//   acc_we            : one-cycle accumulator write pulse
//   pc                : program counter
//   halted, illegal   : HALTED state flag, sticky undefined-opcode flag
// ---------------------------------------------------------------------------
module simple_cpu_seq
   import simple_cpu_pkg::*;
#(
   parameter int                DATA_W   = 8,
   parameter int                ADDR_W   = 8,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   simple_cpu_seq_if.master    mem,
   input  logic [DATA_W-1:0]   acc_q,
   input  logic                acc_zero,
   output logic [1:0]          alu_op,
   output logic [DATA_W-1:0]   operand,
   output logic                acc_we,
   output logic [ADDR_W-1:0]   pc,
   output logic                halted,
   output logic                illegal
);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [7:0]        ir_q, ir_d;
   logic [DATA_W-1:0] arg_q, arg_d;       // raw argument byte (imm or address)
   logic [DATA_W-1:0] opnd_q, opnd_d;     // ALU B operand (imm or loaded data)
   logic [DATA_W-1:0] wdata_q, wdata_d;   // STA data, frozen on MEM_ACC entry
   logic              illegal_q, illegal_d;

   dec_t dec_ir;
   assign dec_ir = decode(ir_q);

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      ir_d      = ir_q;
      arg_d     = arg_q;
      opnd_d    = opnd_q;
      wdata_d   = wdata_q;
      illegal_d = illegal_q;
      mem.req   = 1'b0;
      mem.we    = 1'b0;
      mem.addr  = '0;
      acc_we    = 1'b0;

      case (state_q)
         ST_IDLE, ST_HALTED: begin
            if (start) begin
               pc_d    = RESET_PC;
               state_d = ST_FETCH_OP;
            end
         end

         ST_FETCH_OP: begin
            mem.req  = 1'b1;
            mem.addr = pc_q;
            if (mem.ack) begin
               ir_d    = mem.rdata[7:0];
               pc_d    = pc_q + 1'b1;
               // Branch on the byte arriving now; IR only holds it next cycle.
               state_d = op_has_arg(mem.rdata[7:0]) ? ST_FETCH_ARG : ST_EXECUTE;
            end
         end

         ST_FETCH_ARG: begin
            mem.req  = 1'b1;
            mem.addr = pc_q;
            if (mem.ack) begin
               arg_d  = mem.rdata;
               opnd_d = mem.rdata;
               pc_d   = pc_q + 1'b1;
               if (dec_ir.mem_acc) begin
                  // Freeze the store data so it cannot move during wait states.
                  wdata_d = acc_q;
                  state_d = ST_MEM_ACC;
               end else begin
                  state_d = ST_EXECUTE;
               end
            end
         end

         ST_MEM_ACC: begin
            mem.req  = 1'b1;
            mem.we   = (ir_q == OP_STA);
            mem.addr = ADDR_W'(arg_q);
            if (mem.ack) begin
               if (ir_q == OP_LDA) opnd_d = mem.rdata;
               state_d = ST_EXECUTE;
            end
         end

         ST_EXECUTE: begin
            acc_we = dec_ir.acc_wr;
            if (dec_ir.is_jmp || (dec_ir.is_jz && acc_zero)) pc_d = ADDR_W'(arg_q);
            if (dec_ir.illegal) illegal_d = 1'b1;
            state_d = dec_ir.is_hlt ? ST_HALTED : ST_FETCH_OP;
         end

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         pc_q      <= RESET_PC;
         ir_q      <= '0;
         arg_q     <= '0;
         opnd_q    <= '0;
         wdata_q   <= '0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         ir_q      <= ir_d;
         arg_q     <= arg_d;
         opnd_q    <= opnd_d;
         wdata_q   <= wdata_d;
         illegal_q <= illegal_d;
      end
   end

   assign mem.wdata = wdata_q;
   // IR resets to NOP, so alu_op idles at PASS.
   assign alu_op    = dec_ir.alu_op;
   assign operand   = opnd_q;
   assign pc        = pc_q;
   assign halted    = (state_q == ST_HALTED);
   assign illegal   = illegal_q;

endmodule

// File: doc/simple_cpu_seq.md
Name: simple_cpu_seq

Overview:
Fetch/decode/execute sequencer for the 8-bit accumulator CPU. It owns the program counter and instruction register, fetches instructions over a req/ack memory port, and drives the accumulator datapath with an ALU op, an operand and a one-cycle write enable. It sits between instruction/data memory and the accumulator/ALU datapath.

Parameters:
DATA_W, 8, width of data bus, accumulator and operands
ADDR_W, 8, width of PC and memory address
RESET_PC, 0, PC value loaded at reset and on every start

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins execution from IDLE or HALTED
mem_req  out  1  memory request, held until acknowledged
mem_we  out  1  1 = write (STA), 0 = read
mem_addr  out  ADDR_W  request address
mem_wdata  out  DATA_W  write data (STA)
mem_rdata  in  DATA_W  read data, valid in the cycle mem_ack=1
mem_ack  in  1  completes the current request; ignored while mem_req=0
acc_q  in  DATA_W  current accumulator value from the datapath
acc_zero  in  1  accumulator == 0 flag from the datapath
alu_op  out  2  00 PASS, 01 ADD, 10 SUB, 11 AND
operand  out  DATA_W  ALU B operand
acc_we  out  1  one-cycle pulse: acc <= alu(acc, operand, alu_op)
pc  out  ADDR_W  program counter
halted  out  1  high in HALTED
illegal  out  1  sticky: undefined opcode executed

Behaviour:
- Reset (async, rst_n=0): state IDLE, pc=RESET_PC, IR=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, alu_op=00, operand=0, acc_we=0, halted=0, illegal=0. Reset mid-transaction drops mem_req immediately. A late ack is ignored.
- Encoding: opcode byte at pc. Two-byte ops read their argument at pc+1.
- 0x00 NOP
- 0x01 LDI imm: PASS
- 0x02 ADDI imm
- 0x03 SUBI imm
- 0x04 ANDI imm
- 0x05 LDA addr: PASS mem[addr]
- 0x06 STA addr: mem[addr] <= acc_q
- 0x07 JMP addr
- 0x08 JZ addr: jump if acc_zero
- 0xFF HLT
- Any other opcode executes as NOP and sets illegal. illegal is cleared only by reset.
- States: IDLE, FETCH_OP, FETCH_ARG, MEM_ACC, EXECUTE, HALTED.
- IDLE: start -> pc=RESET_PC, go to FETCH_OP.
- FETCH_OP: req read at pc. On ack: IR<=rdata, pc<=pc+1. Go to FETCH_ARG for ops 0x01-0x08, else EXECUTE.
- FETCH_ARG: req read at pc. On ack: arg<=rdata, pc<=pc+1. Go to MEM_ACC for LDA/STA, else EXECUTE.
- MEM_ACC: req at arg. For STA, mem_we=1 and mem_wdata=acc_q, captured at state entry and held stable. On ack: LDA latches rdata as operand. Go to EXECUTE.
- EXECUTE, exactly one cycle:
  - ALU ops and LDA: acc_we=1 with alu_op/operand valid in that same cycle.
  - JMP: pc<=arg. JZ: pc<=arg only if acc_zero is sampled high in EXECUTE.
  - HLT: go to HALTED. All others: go to FETCH_OP.
- HALTED: halted=1, no requests. start -> pc=RESET_PC, go to FETCH_OP.
- start is ignored outside IDLE/HALTED.
- Handshake: mem_addr/mem_we/mem_wdata stay stable while mem_req=1 and !mem_ack. mem_ack may arrive in the first req cycle (zero wait). mem_req drops the cycle after the ack unless the next state also requests; back-to-back requests are allowed.
- pc increments modulo 2^ADDR_W (0xFF -> 0x00). The argument fetch also wraps.
- Zero-wait latency, start to first acc_we: LDI 3 cycles, LDA 4 cycles. NOP occupies 2 cycles.
- acc_we is never asserted outside EXECUTE and never for longer than 1 cycle.

Decomposition:
- Package simple_cpu_pkg holds:
  - opcode localparams (OP_NOP..OP_HLT)
  - alu_op encodings (ALU_PASS/ADD/SUB/AND)
  - state enum
- No sub-module. Single FSM with PC/IR/arg registers. Decode is a function in the package.

Test Plan:
- Zero-wait memory, program {01 05, 02 03, FF}, start -> acc_we pulses with (PASS,05) then (ADD,03); halted=1; pc=0x05.
- Same program with 2-cycle ack delay per access -> mem_addr/mem_req stable through each wait; identical acc_we sequence; no extra acc_we.
- {06 80, FF} with acc_q=0x5A -> one write request addr=0x80, wdata=0x5A, we=1; then halted.
- {08 10} at 0x00, acc_zero=1 -> next fetch at 0x10. Same with acc_zero=0 -> next fetch at 0x02.
- Opcode 0x3C at pc=0xFF -> illegal=1, next fetch at 0x00 (wrap). illegal stays 1 after later start.
- rst_n asserted while mem_req=1 and ack pending -> all outputs at reset values the same cycle; a subsequent ack has no effect; start resumes from RESET_PC.
